addsub_seq: RTL and testbench

Parametrised multi-cycle adder/subtractor, the successor to the 8-bit ripple-carry add/sub unit. Generic WIDTH operands are processed CHUNK bits per clock. A valid/ready handshake sits on both input and output. Produces sum/difference plus carry, signed-overflow and zero flags, for use as a shared arithmetic resource in datapaths where a full-width single-cycle ripple chain is too slow.

---
 rtl/addsub_seq.sv | 123 ++++++++++++
 tb/tb_addsub_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor: CHUNK bits per clock behind valid/ready
// handshakes, producing z plus carry, signed-overflow and zero flags.
module addsub_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             Cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCYC = WIDTH / CHUNK;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb;
  logic             carry;
  logic [CW-1:0]    count;

  logic             last;
  int               bit_idx;
  logic [CHUNK-1:0] sum_chunk;
  logic             carry_nxt;
  logic             cin_msb;
  logic [WIDTH-1:0] z_nxt;

  assign last = (count == CW'(NCYC - 1));

  // One CHUNK-wide slice of the ripple chain, selected by count.
  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    bit_idx                 = int'(count) * CHUNK;
    {carry_nxt, sum_chunk}  = {1'b0, opa[bit_idx +: CHUNK]}
                            + {1'b0, opb[bit_idx +: CHUNK]}
                            + {{CHUNK{1'b0}}, carry};
    z_nxt                   = z;
    z_nxt[bit_idx +: CHUNK] = sum_chunk;
    // Only meaningful on the top chunk: recovers the carry into the MSB.
    cin_msb                 = sum_chunk[CHUNK-1] ^ opa[WIDTH-1] ^ opb[WIDTH-1];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together on the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, because z and the flags have
  // defined values out of reset rather than being don't-care.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      count <= '0;
      z     <= '0;
      Cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub;
            count <= '0;
            z     <= '0;
          end
        end
        BUSY: begin
          z     <= z_nxt;
          carry <= carry_nxt;
          count <= count + CW'(1);
          if (last) begin
            Cout <= carry_nxt;
            ovf  <= cin_msb ^ carry_nxt;
            zero <= (z_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Scoreboard bench for addsub_seq: 8-bit/CHUNK=2 directed cases plus a
// WIDTH=16 sweep over CHUNK = 1, 4 and 16.
module tb_addsub_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv8, ir8, ov8, or8, sub8, c8, v8, zf8;
  logic [7:0] a8, b8, z8;

  logic        iv16[3], ir16[3], ov16[3], sub16[3], c16[3], v16[3], zf16[3];
  logic [15:0] a16[3], b16[3], z16[3];

  addsub_seq #(.WIDTH(8), .CHUNK(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .sub(sub8), .out_valid(ov8), .out_ready(or8),
    .z(z8), .Cout(c8), .ovf(v8), .zero(zf8)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    addsub_seq #(.WIDTH(16), .CHUNK(g == 0 ? 1 : (g == 1 ? 4 : 16))) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16[g]), .in_ready(ir16[g]),
      .a(a16[g]), .b(b16[g]), .sub(sub16[g]), .out_valid(ov16[g]),
      .out_ready(1'b1), .z(z16[g]), .Cout(c16[g]), .ovf(v16[g]), .zero(zf16[g])
    );
  end

  typedef struct {
    logic [15:0] z;
    logic        c;
    logic        v;
    logic        zf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit pov8   = 1'b0;
  bit pov16[3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every DONE cycle against the queue head, pops on transfer.
  always @(negedge clk) begin
    exp_t e;
    if (ov8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected8: result z=%0d with empty scoreboard", z8);
      end else begin
        e = q8[0];
        if (!pov8) check("latency8", cyc - e.acc, e.lat);
        check("z8", z8, e.z);
        check("cout8", c8, e.c);
        check("ovf8", v8, e.v);
        check("zero8", zf8, e.zf);
        if (or8) void'(q8.pop_front());
      end
    end
    pov8 <= ov8;
    for (int g = 0; g < 3; g++) begin
      if (ov16[g]) begin
        if (q16.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected16[%0d]: result z=%0d with empty scoreboard", g, z16[g]);
        end else begin
          e = q16[0];
          if (!pov16[g]) check($sformatf("latency16[%0d]", g), cyc - e.acc, e.lat);
          check($sformatf("z16[%0d]", g), z16[g], e.z);
          check($sformatf("cout16[%0d]", g), c16[g], e.c);
          check($sformatf("ovf16[%0d]", g), v16[g], e.v);
          check($sformatf("zero16[%0d]", g), zf16[g], e.zf);
          void'(q16.pop_front());
        end
      end
      pov16[g] <= ov16[g];
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [7:0] ez, input logic ec, input logic ev,
                        input logic ezf, input bit push);
    int n = 0;
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; iv8 = 1'b1;
    while (!ir8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ir8) begin
      checks++; errors++;
      $display("FAIL accept8: in_ready stayed 0 for a=%0d b=%0d", a, b);
      iv8 = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (push) q8.push_back('{z: {8'h00, ez}, c: ec, v: ev, zf: ezf, lat: 4, acc: cyc});
    iv8 = 1'b0;
    // Scramble inputs after acceptance; the DUT must not look at them.
    a8 = ~a; b8 = ~b; sub8 = ~s;
  endtask

  task automatic issue16(input int g, input logic [15:0] a, input logic [15:0] b, input logic s);
    int n = 0;
    logic [15:0] ez;
    logic        ec, ev;
    ez = s ? a - b : a + b;
    ec = s ? (a >= b) : ((32'(a) + 32'(b)) > 32'hFFFF);
    ev = s ? ((a[15] != b[15]) && (ez[15] != a[15])) : ((a[15] == b[15]) && (ez[15] != a[15]));
    @(negedge clk);
    a16[g] = a; b16[g] = b; sub16[g] = s; iv16[g] = 1'b1;
    while (!ir16[g] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ir16[g]) begin
      checks++; errors++;
      $display("FAIL accept16[%0d]: in_ready stayed 0", g);
      iv16[g] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    q16.push_back('{z: ez, c: ec, v: ev, zf: (ez == 16'h0), lat: (g == 0) ? 16 : ((g == 1) ? 4 : 1), acc: cyc});
    iv16[g] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0 || q16.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d/%0d results never appeared", q8.size(), q16.size());
      q8.delete();
      q16.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; sub8 = 1'b0;
    for (int g = 0; g < 3; g++) begin
      iv16[g] = 1'b0; a16[g] = '0; b16[g] = '0; sub16[g] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("rst_in_ready", ir8, 1);
    check("rst_out_valid", ov8, 0);
    check("rst_z", z8, 0);
    check("rst_cout", c8, 0);
    check("rst_ovf", v8, 0);
    check("rst_zero", zf8, 0);
    rst_n = 1'b1;

    // a, b, sub, z, Cout, ovf, zero
    issue8(8'd100, 8'd27,  1'b0, 8'd127, 1'b0, 1'b0, 1'b0, 1'b1);
    issue8(8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b1, 1'b0, 1'b1);
    issue8(8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0, 1'b0, 1'b1);
    issue8(8'd5,   8'd5,   1'b1, 8'd0,   1'b1, 1'b0, 1'b1, 1'b1);
    issue8(8'd3,   8'd5,   1'b1, 8'd254, 1'b0, 1'b0, 1'b0, 1'b1);
    issue8(8'd128, 8'd1,   1'b1, 8'd127, 1'b1, 1'b1, 1'b0, 1'b1);
    issue8(8'd0,   8'd0,   1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 1'b1);
    issue8(8'd255, 8'd1,   1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 1'b1);
    issue8(8'd0,   8'd1,   1'b1, 8'd255, 1'b0, 1'b0, 1'b0, 1'b1);
    issue8(8'd127, 8'd255, 1'b1, 8'd128, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();

    // Backpressure: result held for 3 cycles while new operands wait.
    or8 = 1'b0;
    issue8(8'd50, 8'd60, 1'b0, 8'd110, 1'b0, 1'b0, 1'b0, 1'b1);
    begin
      int n = 0;
      while (!ov8 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    fork
      issue8(8'd1, 8'd2, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0, 1'b1);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_in_ready", ir8, 0);
          check("bp_out_valid", ov8, 1);
        end
        @(posedge clk);
        #1 or8 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_in_ready", ir8, 1);
      end
    join
    drain();

    // Asynchronous reset in the middle of BUSY (count == 2).
    issue8(8'd10, 8'd99, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", ov8, 0);
    check("abort_z", z8, 0);
    check("abort_in_ready", ir8, 1);
    @(negedge clk);
    rst_n = 1'b1;
    issue8(8'd10, 8'd20, 1'b0, 8'd30, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i <= 30; i++) begin
        issue16(g, 16'(2 * i), 16'(i), 1'b0);
        issue16(g, 16'(2 * i), 16'(i), 1'b1);
      end
      issue16(g, 16'hFFFF, 16'h0001, 1'b0);
      issue16(g, 16'h0003, 16'h0005, 1'b1);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
